// File: rtl/uart_pkg.sv
// Shared state encodings for the uart_port transmitter and receiver FSMs.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAITHI
  } rx_state_t;

endpackage

// File: rtl/uart_baudcnt.sv
// Reloadable bit-period down-counter; tick is high while the count is zero, then it reloads.
// Zero latency from load; no backpressure.
module uart_baudcnt #(
  parameter int unsigned DIV = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic half,
  output logic tick
);

  localparam int unsigned W = $clog2(DIV);
  localparam logic [W-1:0] FULL_CNT = W'(DIV - 1);
  localparam logic [W-1:0] HALF_CNT = W'(DIV / 2 - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= FULL_CNT;
    end else if (load) begin
      cnt <= half ? HALF_CNT : FULL_CNT;
    end else if (cnt == '0) begin
      cnt <= FULL_CNT;
    end else begin
      cnt <= cnt - W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_port.sv
// 8N1 UART transceiver: txd falls one cycle after accept, frame is 10*BAUDDIV cycles.
// tx_ready low for the whole frame; single-byte RX holding register, overrun drops the new byte.
module uart_port
  import uart_pkg::*;
#(
  parameter int unsigned BAUDDIV = 26
) (
  input  logic       clk,
  input  logic       power_on_reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  input  logic       err_clr,
  output logic       txd,
  input  logic       rxd
);

  // ---------------- transmitter ----------------
  tx_state_t  tx_state, tx_state_nx;
  logic [7:0] tx_shreg;
  logic [2:0] tx_idx;
  logic       tx_tick;
  logic       tx_accept;

  assign tx_accept = tx_valid && tx_ready;

  uart_baudcnt #(.DIV(BAUDDIV)) u_tx_cnt (
    .clk  (clk),
    .rst  (power_on_reset),
    .load (tx_accept),
    .half (1'b0),
    .tick (tx_tick)
  );

  always_comb begin
    tx_state_nx = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_accept) tx_state_nx = TX_START;
      TX_START: if (tx_tick) tx_state_nx = TX_DATA;
      TX_DATA:  if (tx_tick && tx_idx == 3'd7) tx_state_nx = TX_STOP;
      TX_STOP:  if (tx_tick) tx_state_nx = TX_IDLE;
      default:  tx_state_nx = TX_IDLE;
    endcase
  end

  // txd and tx_ready are registered off the state, so both lag it by one cycle.
  always_ff @(posedge clk or posedge power_on_reset) begin
    if (power_on_reset) begin
      tx_state <= TX_IDLE;
      tx_shreg <= '0;
      tx_idx   <= '0;
      tx_ready <= 1'b1;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_ready <= (tx_state == TX_IDLE) && !tx_accept;
      if (tx_accept) begin
        tx_shreg <= tx_data;
        tx_idx   <= '0;
      end else if (tx_state == TX_DATA && tx_tick) begin
        tx_shreg <= {1'b0, tx_shreg[7:1]};
        tx_idx   <= tx_idx + 3'd1;
      end
      case (tx_state)
        TX_START: txd <= 1'b0;
        TX_DATA:  txd <= tx_shreg[0];
        default:  txd <= 1'b1;
      endcase
    end
  end

  // ---------------- receiver ----------------
  rx_state_t  rx_state, rx_state_nx;
  logic       rxd_meta, rs, rs_d;
  logic [7:0] rx_shreg;
  logic [2:0] rx_idx;
  logic       rx_tick;
  logic       rx_load;
  logic       rx_sample;
  logic       rx_deliver;
  logic       frame_set;
  logic       overrun_set;
  logic       rx_pop;

  always_ff @(posedge clk or posedge power_on_reset) begin
    if (power_on_reset) begin
      rxd_meta <= 1'b1;
      rs       <= 1'b1;
      rs_d     <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rs       <= rxd_meta;
      rs_d     <= rs;
    end
  end

  uart_baudcnt #(.DIV(BAUDDIV)) u_rx_cnt (
    .clk  (clk),
    .rst  (power_on_reset),
    .load (rx_load),
    .half (1'b1),
    .tick (rx_tick)
  );

  // Start is a falling edge, so a line held low out of reset is never decoded.
  always_comb begin
    rx_state_nx = rx_state;
    rx_load     = 1'b0;
    rx_sample   = 1'b0;
    rx_deliver  = 1'b0;
    frame_set   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rs && rs_d) begin
          rx_state_nx = RX_START;
          rx_load     = 1'b1;
        end
      end
      RX_START: begin
        if (rx_tick) rx_state_nx = rs ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_sample = 1'b1;
          if (rx_idx == 3'd7) rx_state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          if (rs) begin
            rx_deliver  = 1'b1;
            rx_state_nx = RX_IDLE;
          end else begin
            frame_set   = 1'b1;
            rx_state_nx = RX_WAITHI;
          end
        end
      end
      RX_WAITHI: begin
        if (rs) rx_state_nx = RX_IDLE;
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  assign rx_pop      = rx_valid && rx_ready;
  assign overrun_set = rx_deliver && rx_valid && !rx_ready;

  always_ff @(posedge clk or posedge power_on_reset) begin
    if (power_on_reset) begin
      rx_state     <= RX_IDLE;
      rx_shreg     <= '0;
      rx_idx       <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_state <= rx_state_nx;
      if (rx_state == RX_START) begin
        rx_idx <= '0;
      end else if (rx_sample) begin
        rx_shreg <= {rs, rx_shreg[7:1]};
        rx_idx   <= rx_idx + 3'd1;
      end
      if (rx_deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= rx_shreg;
        rx_valid <= 1'b1;
      end else if (rx_pop) begin
        rx_valid <= 1'b0;
      end
      rx_overrun   <= overrun_set || (rx_overrun && !err_clr);
      rx_frame_err <= frame_set || (rx_frame_err && !err_clr);
    end
  end

endmodule

// File: tb/tb_uart_port.sv
// Directed bench for uart_port at BAUDDIV=26: TX waveform, loopback, glitch, framing, overrun, reset.
module tb_uart_port;
  import uart_pkg::*;

  localparam int BD = 26;

  logic       clk = 1'b0;
  logic       power_on_reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       err_clr;
  logic       txd;
  logic       rxd;
  logic       loop_en;
  logic       rxd_drv;

  int n_checks = 0;
  int n_errors = 0;

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  uart_port #(.BAUDDIV(BD)) dut (
    .clk          (clk),
    .power_on_reset(power_on_reset),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .err_clr      (err_clr),
    .txd          (txd),
    .rxd          (rxd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds tx_valid until the byte is taken; returns on the negedge after the accept edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("tx_accept_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    rxd_drv = 1'b0;
    idle(BD);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      idle(BD);
    end
    rxd_drv = stop_bit;
    idle(BD);
  endtask

  task automatic wait_rx(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (!rx_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_vld"}, 32'(rx_valid), 32'd1);
    check(tag, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check({tag, "_pop"}, 32'(rx_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat;
    logic       exp_bit;
    int         idx;

    power_on_reset = 1'b1;
    tx_data  = '0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    err_clr  = 1'b0;
    loop_en  = 1'b0;
    rxd_drv  = 1'b1;

    // Reset
    repeat (3) @(negedge clk);
    power_on_reset = 1'b0;
    @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_overrun", 32'(rx_overrun), 32'd0);
    check("rst_frame_err", 32'(rx_frame_err), 32'd0);

    // TX 0x55 waveform, sampled at the negedge after edge N+k
    pat = 8'h55;
    tx_data  = pat;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_drop", 32'(tx_ready), 32'd0);
    check("tx_txd_pre", 32'(txd), 32'd1);
    for (int k = 1; k <= 261; k++) begin
      @(negedge clk);
      idx = (k - 1) / BD;
      if (idx == 0) exp_bit = 1'b0;
      else if (idx >= 9) exp_bit = 1'b1;
      else exp_bit = pat[idx-1];
      if (k == 1) check("tx_start_fall", 32'(txd), 32'd0);
      if (k == BD) check("tx_start_last", 32'(txd), 32'd0);
      if (k == BD + 1) check("tx_bit0_first", 32'(txd), 32'd1);
      if (k <= 260 && (k - 1) % BD == BD / 2) check("tx_bit_mid", 32'(txd), 32'(exp_bit));
      if (k == 260) check("tx_ready_260", 32'(tx_ready), 32'd0);
      if (k == 261) begin
        check("tx_ready_261", 32'(tx_ready), 32'd1);
        check("tx_idle_261", 32'(txd), 32'd1);
      end
    end

    // Loopback of two back-to-back bytes
    idle(5);
    loop_en = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h3C);
    wait_rx("lb_a5", 8'hA5);
    wait_rx("lb_3c", 8'h3C);
    check("lb_overrun", 32'(rx_overrun), 32'd0);
    idle(40);
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    idle(10);

    // Glitch on rxd
    rxd_drv = 1'b0;
    idle(5);
    rxd_drv = 1'b1;
    idle(60);
    check("glitch_rx_valid", 32'(rx_valid), 32'd0);
    check("glitch_frame_err", 32'(rx_frame_err), 32'd0);
    check("glitch_idle", 32'(dut.rx_state), 32'(RX_IDLE));

    // Framing error followed by a long break
    drive_frame(8'hFF, 1'b0);
    idle(500);
    check("fe_flag", 32'(rx_frame_err), 32'd1);
    check("fe_no_byte", 32'(rx_valid), 32'd0);
    check("fe_waithi", 32'(dut.rx_state), 32'(RX_WAITHI));
    rxd_drv = 1'b1;
    idle(30);
    drive_frame(8'h12, 1'b1);
    wait_rx("fe_12", 8'h12);
    check("fe_sticky", 32'(rx_frame_err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("fe_clr", 32'(rx_frame_err), 32'd0);

    // Overrun
    idle(10);
    drive_frame(8'h11, 1'b1);
    drive_frame(8'h22, 1'b1);
    idle(20);
    check("ov_valid", 32'(rx_valid), 32'd1);
    check("ov_data", 32'(rx_data), 32'h11);
    check("ov_flag", 32'(rx_overrun), 32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("ov_pop", 32'(rx_valid), 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ov_clr", 32'(rx_overrun), 32'd0);

    // Reset in the middle of data bit 3 of 0xF0
    send_byte(8'hF0);
    idle(1 + 4 * BD + BD / 2);
    check("mid_bit3_low", 32'(txd), 32'd0);
    power_on_reset = 1'b1;
    #1;
    check("mid_rst_txd", 32'(txd), 32'd1);
    check("mid_rst_ready", 32'(tx_ready), 32'd1);
    idle(2);
    power_on_reset = 1'b0;
    idle(3);
    check("post_rst_txd", 32'(txd), 32'd1);
    check("post_rst_ready", 32'(tx_ready), 32'd1);
    check("post_rst_rx_valid", 32'(rx_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_port.md
# uart_port

Byte-wide UART transceiver between the 3 MHz `system` clock domain and the board's serial pins (TX/RX on the serial header). It sits downstream of the system core's peripheral bus and directly upstream of the pad-level pin assignments. It replaces bit-banging on the serial GPIO bits. The format is 8N1, LSB first, with a fixed baud rate set by parameter, a one-byte receive holding register and sticky error flags.

## Interface
- `BAUDDIV`, 26: clock cycles per bit. The default gives 3 MHz / 26 ≈ 115200 baud. Legal range is 4..65535.
- `clk` in 1: system clock (3 MHz). All logic is on the rising edge.
- `power_on_reset` in 1: reset, asynchronous and active-high.
- `tx_data` in 8: byte to transmit.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: the transmitter can accept a byte.
- `rx_data` out 8: received byte (holding register).
- `rx_valid` out 1: the holding register is full.
- `rx_ready` in 1: the consumer takes the held byte.
- `rx_overrun` out 1: sticky; a byte arrived while the holding register was full.
- `rx_frame_err` out 1: sticky; a stop bit was sampled low.
- `err_clr` in 1: clears both sticky flags.
- `txd` out 1: serial output pin; idles high.
- `rxd` in 1: serial input pin, asynchronous.

## Operation
- **Reset values:** `txd`=1, `tx_ready`=1, `rx_valid`=0, `rx_data`=0x00, `rx_overrun`=0, `rx_frame_err`=0. Both FSMs reset to IDLE, and the rxd synchroniser resets to 1.
- **TX FSM:** IDLE → START → DATA → STOP → IDLE.
  - **Accept:** a byte is accepted when `tx_valid && tx_ready`. `tx_ready` is 1 only in IDLE.
  - **START:** `txd`=0 for BAUDDIV cycles.
  - **DATA:** 8 bits, each for BAUDDIV cycles, bit 0 first, taken from a latched shift register. `tx_data` may change after acceptance.
  - **STOP:** `txd`=1 for BAUDDIV cycles.
- **RX sync:** `rxd` passes through a 2-FF synchroniser. All RX decisions use the synchronised value `rs`.
- **RX FSM states:**
  - **IDLE:** go to START when `rs`=0.
  - **START:** wait BAUDDIV/2 cycles (integer division). If `rs`=0, go to DATA; otherwise treat as a glitch and return to IDLE.
  - **DATA:** sample `rs` every BAUDDIV cycles, 8 samples, shifting in LSB first.
  - **STOP:** sample after BAUDDIV cycles.
    - If the sample is 1: deliver the byte and go to IDLE.
    - If the sample is 0: set `rx_frame_err`, discard the byte, and go to WAITHI.
  - **WAITHI:** stay until `rs`=1, then go to IDLE. This prevents a break condition from being decoded as repeated 0x00 bytes.
- **Delivery:** occurs on the cycle the stop sample is taken.
  - If `rx_valid`=0, or `rx_ready`=1 in the same cycle: load `rx_data` and set `rx_valid`=1.
  - Otherwise: keep the old byte, drop the new one, and set `rx_overrun`.
- **Pop:** when `rx_valid && rx_ready`, `rx_valid` clears next cycle unless a delivery happens in that same cycle. `rx_ready` while `rx_valid`=0 is ignored.
- **Sticky flags:** `err_clr` clears both flags. If a set event and `err_clr` coincide, the set wins.
- **Concurrency:** TX and RX are fully independent. They may run concurrently, including in loopback (`txd` tied to `rxd`).
- **Reset mid-operation:** an asserted reset aborts any frame immediately; `txd` goes to 1 asynchronously. After reset is released, RX ignores a line that is already low until it has seen `rs`=1, because the synchroniser resets to 1 and a falling edge is required.

## Timing
- **TX latency:** acceptance at edge N. `txd` falls at edge N+1.
- **TX frame:** the frame lasts exactly 10·BAUDDIV cycles. `tx_ready` rises at edge N+1+10·BAUDDIV.
- **Back-to-back TX:** a byte held valid is accepted on the cycle `tx_ready` rises. Frames follow with no extra idle gap.
- **RX data samples:** the first start-low `rs` is at cycle S. Data bit k is sampled at S + BAUDDIV/2 + (k+1)·BAUDDIV.
- **RX stop sample:** taken at S + BAUDDIV/2 + 9·BAUDDIV. `rx_valid` is visible on the next cycle.
- **RX pin delay:** pin-to-`rs` delay is 2 cycles.
- **Counter width:** bit counters are `$clog2(BAUDDIV)` bits wide. They count down from BAUDDIV-1 and reload on reaching zero, with no wrap past zero. The bit index is a 3-bit counter, and the frame ends on index 7.

## Structure
- **Package `uart_pkg`:** holds the `tx_state_t` enum (IDLE, START, DATA, STOP) and the `rx_state_t` enum (IDLE, START, DATA, STOP, WAITHI).
- **Sub-module `uart_baudcnt`:** a reloadable down-counter with a `tick` output and `load`/`half` inputs. It is instantiated once for TX and once for RX.
- **Top-level integration:** the top level instantiates `uart_port` and ties `txd` to TX and `rxd` to RX, replacing the current GPIO assignments on those pins.

## Test plan
All scenarios use BAUDDIV=26.
- **Reset:** hold `power_on_reset` for 3 cycles, then release → `txd`=1, `tx_ready`=1, `rx_valid`=0, and both flags 0.
- **TX 0x55:** send 0x55 → `txd` is low for 26 cycles, then alternates 1,0,1,0,1,0,1,0 with 26 cycles per bit, then high for 26. `tx_ready` rises 261 cycles after the accept edge.
- **Loopback:** loop back 0xA5 followed immediately by 0x3C with no gap → `rx_data` reads 0xA5 then 0x3C, each popped with `rx_ready`. `rx_overrun`=0.
- **Glitch:** drive `rxd` low for 5 cycles → no byte delivered, and the FSM is back in IDLE.
- **Frame error:** send a frame for 0xFF with the stop bit driven low, then hold the line low for 500 cycles → `rx_frame_err`=1, no `rx_valid`, no further bytes. After the line goes high, 0x12 is received correctly. Pulsing `err_clr` clears the flag.
- **Overrun and reset mid-frame:**
  - Receive 0x11 and 0x22 without popping → `rx_data`=0x11 and `rx_overrun`=1.
  - Assert reset mid-TX at bit 3 → `txd`=1 immediately, and `tx_ready`=1 after release.
